// File: rtl/pe_pkg.sv
// Shared widths, helpers and bundle types
// for the dot-product MAC processing element.
package pe_pkg;

  localparam int DATA_W_D    = 8;
  localparam int LANES_D     = 4;
  localparam int ACC_W_D     = 24;
  localparam int OUT_W_D     = 8;
  localparam int SHIFT_W_D   = 5;
  localparam int MAX_SHIFT_W = 8;
  localparam int CALC_W      = 64;

  typedef struct packed {
    logic                   first;
    logic                   last;
    logic                   signed_mode;
    logic [MAX_SHIFT_W-1:0] shift_amt;
  } s1_side_t;

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v << 1;
      r++;
    end
    return r;
  endfunction

  // Returns {result, sat}. value is pre-extended
  // to CALC_W according to sgn.
  function automatic logic [CALC_W:0] sat_round(
    input logic [CALC_W-1:0] value,
    input int unsigned       shift,
    input logic              sgn,
    input int unsigned       acc_w,
    input int unsigned       out_w
  );
    logic [CALC_W-1:0] rnd;
    logic [CALC_W-1:0] sum;
    logic [CALC_W-1:0] sh;
    logic [CALC_W-1:0] hi;
    logic [CALC_W-1:0] lo;
    logic [CALC_W-1:0] res;
    logic              sat;
    rnd = '0;
    sum = value;
    sat = 1'b0;
    // Shifting out every accumulator bit leaves
    // only the sign, with no rounding carry.
    if (shift >= acc_w) begin
      sh = (sgn && value[CALC_W-1]) ? '1 : '0;
    end else begin
      if (shift != 0)
        rnd = CALC_W'(1) << (shift - 1);
      sum = value + rnd;
      if (sgn) sh = $signed(sum) >>> shift;
      else     sh = sum >> shift;
    end
    if (sgn) begin
      hi = (CALC_W'(1) << (out_w - 1)) - CALC_W'(1);
      lo = ~hi;
      if ($signed(sh) > $signed(hi)) begin
        res = hi;
        sat = 1'b1;
      end else if ($signed(sh) < $signed(lo)) begin
        res = lo;
        sat = 1'b1;
      end else begin
        res = sh;
      end
    end else begin
      hi = (CALC_W'(1) << out_w) - CALC_W'(1);
      lo = '0;
      if (sh > hi) begin
        res = hi;
        sat = 1'b1;
      end else begin
        res = sh | lo;
      end
    end
    return {res, sat};
  endfunction

endpackage

// File: rtl/pe_requant.sv
// Combinational round / shift / saturate of
// the accumulator into the output width.
module pe_requant
  import pe_pkg::*;
#(
  parameter int ACC_W   = ACC_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int SHIFT_W = MAX_SHIFT_W
) (
  input  logic [ACC_W-1:0]   value_i,
  input  logic [SHIFT_W-1:0] shift_i,
  input  logic               signed_i,
  output logic [OUT_W-1:0]   res_o,
  output logic               sat_o
);

  logic [CALC_W-1:0] wide;

  // Extend the accumulator to the work width.
  always_comb begin
    if (signed_i) wide = CALC_W'($signed(value_i));
    else          wide = CALC_W'(value_i);
  end

  assign res_o = OUT_W'(sat_round(wide,
    32'(shift_i), signed_i, ACC_W, OUT_W) >> 1);
  assign sat_o = 1'(sat_round(wide,
    32'(shift_i), signed_i, ACC_W, OUT_W));

endmodule

// File: rtl/pe_dot_mac.sv
// LANES-wide dot-product MAC with framed
// accumulation and requantised handshake out.
module pe_dot_mac
  import pe_pkg::*;
#(
  parameter int DATA_W  = DATA_W_D,
  parameter int LANES   = LANES_D,
  parameter int ACC_W   = ACC_W_D,
  parameter int OUT_W   = OUT_W_D,
  parameter int SHIFT_W = SHIFT_W_D
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_first,
  input  logic                    in_last,
  input  logic [LANES*DATA_W-1:0] ifm,
  input  logic [LANES*DATA_W-1:0] weight,
  input  logic                    signed_mode,
  input  logic [SHIFT_W-1:0]      shift_amt,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        ofm,
  output logic                    out_sat,
  output logic                    out_ovf,
  output logic [ACC_W-1:0]        acc_raw
);

  localparam int PW    = 2 * DATA_W;
  localparam int SUM_W = PW + clog2(LANES);

  logic             adv;
  logic             accept;
  logic [PW-1:0]    prod_d [LANES];
  logic [PW-1:0]    prod_q [LANES];
  s1_side_t         side_d;
  s1_side_t         side_q;
  logic             s1_valid_q;
  logic [SUM_W-1:0] tree;
  logic [ACC_W-1:0] psum;
  logic [ACC_W-1:0] base;
  logic             ovf_base;
  logic [ACC_W:0]   sum_c;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;
  logic             wrap;
  logic             ovf_d;
  logic             ovf_q;
  logic [OUT_W-1:0] rq_res;
  logic             rq_sat;
  logic             out_valid_q;
  logic [OUT_W-1:0] ofm_q;
  logic             sat_q;
  logic             ovfo_q;
  logic [ACC_W-1:0] raw_q;

  assign adv      = !out_valid_q || out_ready;
  assign in_ready = reset_n && adv;
  assign accept   = in_valid && in_ready;

  // Per-lane products and beat sideband.
  always_comb begin
    logic [PW-1:0] a;
    logic [PW-1:0] b;
    for (int i = 0; i < LANES; i++) begin
      if (signed_mode) begin
        a = PW'($signed(ifm[i*DATA_W +: DATA_W]));
        b = PW'($signed(weight[i*DATA_W +: DATA_W]));
      end else begin
        a = PW'(ifm[i*DATA_W +: DATA_W]);
        b = PW'(weight[i*DATA_W +: DATA_W]);
      end
      prod_d[i] = a * b;
    end
    side_d.first       = in_first;
    side_d.last        = in_last;
    side_d.signed_mode = signed_mode;
    side_d.shift_amt   = MAX_SHIFT_W'(shift_amt);
  end

  // Stage-1 register, frozen while stalled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      side_q     <= '0;
      for (int i = 0; i < LANES; i++)
        prod_q[i] <= '0;
    end else if (adv) begin
      s1_valid_q <= accept;
      if (accept) begin
        side_q <= side_d;
        for (int i = 0; i < LANES; i++)
          prod_q[i] <= prod_d[i];
      end
    end
  end

  // Adder tree, accumulate and wrap detection.
  always_comb begin
    logic [SUM_W-1:0] ext;
    tree = '0;
    for (int i = 0; i < LANES; i++) begin
      if (side_q.signed_mode)
        ext = SUM_W'($signed(prod_q[i]));
      else
        ext = SUM_W'(prod_q[i]);
      tree = tree + ext;
    end
    if (side_q.signed_mode)
      psum = ACC_W'($signed(tree));
    else
      psum = ACC_W'(tree);
    base     = side_q.first ? '0 : acc_q;
    ovf_base = side_q.first ? 1'b0 : ovf_q;
    sum_c    = {1'b0, base} + {1'b0, psum};
    acc_d    = sum_c[ACC_W-1:0];
    if (side_q.signed_mode)
      wrap = (base[ACC_W-1] == psum[ACC_W-1])
          && (acc_d[ACC_W-1] != base[ACC_W-1]);
    else
      wrap = sum_c[ACC_W];
    ovf_d = ovf_base | wrap;
  end

  pe_requant #(
    .ACC_W   (ACC_W),
    .OUT_W   (OUT_W),
    .SHIFT_W (MAX_SHIFT_W)
  ) u_requant (
    .value_i  (acc_d),
    .shift_i  (side_q.shift_amt),
    .signed_i (side_q.signed_mode),
    .res_o    (rq_res),
    .sat_o    (rq_sat)
  );

  // Accumulator and output register; a last
  // beat publishes and clears the window.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      ofm_q       <= '0;
      sat_q       <= 1'b0;
      ovfo_q      <= 1'b0;
      raw_q       <= '0;
    end else if (adv) begin
      if (s1_valid_q && side_q.last) begin
        acc_q       <= '0;
        ovf_q       <= 1'b0;
        out_valid_q <= 1'b1;
        ofm_q       <= rq_res;
        sat_q       <= rq_sat;
        ovfo_q      <= ovf_d;
        raw_q       <= acc_d;
      end else begin
        out_valid_q <= 1'b0;
        if (s1_valid_q) begin
          acc_q <= acc_d;
          ovf_q <= ovf_d;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign ofm       = ofm_q;
  assign out_sat   = sat_q;
  assign out_ovf   = ovfo_q;
  assign acc_raw   = raw_q;

endmodule

// File: doc/pe_dot_mac.md
Name: pe_dot_mac

Overview:
- Parametrised successor to the scalar 8-bit MAC processing element. Computes a LANES-wide dot product per input beat, accumulates beats over a window framed by first/last flags, and requantises the result to OUT_W with rounding and saturation.
- Uses valid/ready handshakes on input and output, so it can sit between the IFM/weight line buffers and the OFM writer in the fused-block datapath.

Parameters:
- DATA_W, 8, width of each IFM and weight element.
- LANES, 4, elements multiplied per beat (channel parallelism).
- ACC_W, 24, accumulator width; must be >= 2*DATA_W + clog2(LANES).
- OUT_W, 8, requantised output width.
- SHIFT_W, 5, width of shift_amt.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset; one clock, reset asynchronous active-low.
- in_valid  in  1  beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_first  in  1  beat opens a new window.
- in_last  in  1  beat closes the window.
- ifm  in  LANES*DATA_W  packed IFM elements, lane 0 in the LSBs.
- weight  in  LANES*DATA_W  packed weights, lane 0 in the LSBs.
- signed_mode  in  1  1 = two's-complement operands and output; sampled per beat.
- shift_amt  in  SHIFT_W  requant right-shift; sampled on the last beat.
- out_valid  out  1  result valid.
- out_ready  in  1  result consumed when out_valid && out_ready.
- ofm  out  OUT_W  requantised result.
- out_sat  out  1  result was clipped during saturation.
- out_ovf  out  1  accumulator wrapped at least once during the window (sticky).
- acc_raw  out  ACC_W  full accumulator value of the reported window.

Behaviour:
- Reset values: in_ready=0 while reset_n is low and 1 after it; out_valid=0; ofm=0; out_sat=0; out_ovf=0; acc_raw=0. Accumulator, overflow flag and all pipeline valids are 0.
- adv = !out_valid || out_ready; in_ready = adv.
- All pipeline registers update only when adv=1.
- Stage 1 (registered), on acceptance:
  - Per-lane products are DATA_W x DATA_W, signed or unsigned according to signed_mode, each 2*DATA_W bits.
  - first, last, signed_mode and shift_amt are registered alongside.
  - s1_valid <= accepted beat.
- Stage 2, when s1_valid:
  - Lane products are summed by an adder tree, then sign-extended (signed) or zero-extended (unsigned) to ACC_W to form psum.
  - If first: acc_next = psum and the overflow flag clears before evaluation; else acc_next = acc + psum.
  - Overflow detection: signed, operand signs equal and result sign differs; unsigned, carry out. The accumulator wraps modulo 2^ACC_W; ovf becomes sticky.
  - If last: load the output register and set out_valid=1. Set acc=0 and ovf=0 so the next window starts clean.
- Requant, applied combinationally before the output register:
  - If shift_amt > 0, add 1 << (shift_amt-1) in ACC_W+1 bits.
  - Shift right: arithmetic when signed, logical when unsigned.
  - Saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1] (signed) or [0, 2^OUT_W-1] (unsigned); out_sat=1 if clipped.
  - shift_amt >= ACC_W yields 0 (signed positive or unsigned) or -1 (signed negative) before rounding effects.
- Latency: last beat accepted in cycle t, out_valid=1 in cycle t+2. Throughput is 1 beat/cycle with out_ready held high.
- Output register holds ofm, out_sat, out_ovf and acc_raw stable while out_valid && !out_ready. The whole pipeline stalls; no beat or result is dropped.
- Consumption of a result and acceptance of a new beat in the same cycle are allowed.
- Boundary cases:
  - A beat with first && last is a single-beat window.
  - A beat without first after reset or after a last accumulates onto 0.
  - in_first mid-window discards the partial sum.
  - reset_n low mid-operation clears everything immediately; no result is emitted for the aborted window.

Decomposition:
- Package pe_pkg holds:
  - default width constants;
  - function clog2;
  - function sat_round(value, shift, signed_mode), returning result and sat flag;
  - typedef for the stage-1 sideband struct {first, last, signed_mode, shift_amt}.
- One sub-module, pe_requant: combinational round/shift/saturate, instantiated once before the output register.

Test Plan:
- Unsigned, 1 beat first+last, ifm={1,2,3,4}, wgt={5,6,7,8}, shift 0 -> ofm=70, acc_raw=70, out_valid exactly 2 cycles after acceptance.
- Signed, 3 beats, ifm all 0xFF (-1), wgt all 2, shift 2 -> acc_raw=-24; ofm=(-24+2)>>>2=-6=0xFA; out_sat=0.
- Unsigned, ifm all 255, wgt all 255, shift 4 -> acc_raw=260100; ofm=255; out_sat=1.
- Backpressure: out_ready low 5 cycles with result pending and a following 2-beat window offered -> in_ready=0 for those cycles, ofm stable, second result correct after release.
- Framing: 2 beats, then a first+last beat of ifm={1,1,1,1}, wgt={1,1,1,1} -> ofm=4.
- Reset after 2 beats of a window, then one beat without first plus last ({2,0,0,0}·{3,0,0,0}) -> no stale result; ofm=6.
